// File: rtl/sram_fifo_pkg.sv
// Shared definitions for the SRAM FIFO reader: controller state encoding and
// the byte/word widths used to assemble 32-bit words from the 8-bit stream.
package sram_fifo_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/sram_fifo_reader_buf.sv
// Output word buffer: DEPTH x 32-bit synchronous FIFO.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (clears pointers/count)
//   push       : write wr_data at the tail this cycle
//   wr_data    : word to write
//   pop        : drop the head word this cycle (caller guarantees non-empty)
//   rd_data    : head word, forced to zero while empty
//   count      : number of words held (0..DEPTH)
module sram_fifo_reader_buf
  import sram_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [WORD_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sram_fifo_reader.sv
// Reads bytes from an SRAM FIFO with a fixed read latency and assembles them
// little-endian into 32-bit words held in a small output buffer.
// Ports:
//   BUS_CLK, BUS_RST_N : clock, synchronous active-low reset
//   FIFO_NOT_EMPTY     : source holds at least one byte
//   USB_READ           : one-cycle byte read strobe to the source
//   USB_DATA           : byte returned READ_LATENCY cycles after the strobe
//   FIFO_READ_ERROR    : source read-while-empty indication (sets ERROR)
//   FLUSH              : stop reading, discard the partial word
//   DATA_OUT/VALID     : buffer head word / buffer non-empty
//   DATA_READY         : downstream accept; transfer on VALID & READY
//   BUSY               : reads in flight, partial word held, or draining
//   ERROR              : sticky read error
//   WORD_CNT           : words delivered since reset (wrapping)
module sram_fifo_reader
  import sram_fifo_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned BUF_DEPTH    = 4
) (
  input  logic              BUS_CLK,
  input  logic              BUS_RST_N,
  input  logic              FIFO_NOT_EMPTY,
  output logic              USB_READ,
  input  logic [BYTE_W-1:0] USB_DATA,
  input  logic              FIFO_READ_ERROR,
  input  logic              FLUSH,
  output logic [WORD_W-1:0] DATA_OUT,
  output logic              DATA_VALID,
  input  logic              DATA_READY,
  output logic              BUSY,
  output logic              ERROR,
  output logic [15:0]       WORD_CNT
);

  localparam int unsigned CW          = $clog2(BUF_DEPTH) + 1;
  localparam logic [7:0]  TOTAL_BYTES = 8'(LANES * BUF_DEPTH);

  state_t                     state;
  logic [READ_LATENCY-1:0]    rd_pipe;
  logic [2:0]                 inflight;
  logic [1:0]                 byte_cnt;
  logic [WORD_W-BYTE_W-1:0]   partial;
  logic                       error_q;
  logic [15:0]                word_cnt_q;
  logic [CW-1:0]              buf_count;
  logic                       capture;
  logic                       push;
  logic                       pop;
  logic [7:0]                 used_bytes;
  logic [7:0]                 free_bytes;

  assign capture    = rd_pipe[READ_LATENCY-1];
  assign pop        = DATA_VALID && DATA_READY;
  assign used_bytes = 8'({buf_count, 2'b00}) + 8'(byte_cnt) + 8'(inflight);
  assign free_bytes = TOTAL_BYTES - used_bytes;

  // The strobe must track FIFO_NOT_EMPTY in the same cycle, so it is decoded
  // from registered state rather than registered itself. A FLUSH cycle issues
  // no strobe, and a word completing in that cycle is discarded with the rest.
  assign USB_READ = (state == ACTIVE) && FIFO_NOT_EMPTY && !FLUSH &&
                    (free_bytes != 8'd0);
  assign push     = capture && (byte_cnt == 2'd3) && (state == ACTIVE) && !FLUSH;

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state      <= IDLE;
      rd_pipe    <= '0;
      inflight   <= '0;
      byte_cnt   <= '0;
      partial    <= '0;
      error_q    <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      rd_pipe[0] <= USB_READ;
      for (int unsigned i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];

      case ({USB_READ, capture})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   inflight <= inflight - 3'd1;
        default: ;
      endcase

      if (FIFO_READ_ERROR) error_q <= 1'b1;
      if (pop) word_cnt_q <= word_cnt_q + 16'd1;

      case (state)
        IDLE: state <= ACTIVE;
        ACTIVE: begin
          if (capture) begin
            case (byte_cnt)
              2'd0: partial[7:0]   <= USB_DATA;
              2'd1: partial[15:8]  <= USB_DATA;
              2'd2: partial[23:16] <= USB_DATA;
              default: partial     <= '0;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
          end
          if (FLUSH) state <= DRAIN;
        end
        DRAIN: begin
          // Late bytes are consumed via inflight only; the partial word is
          // thrown away once nothing is outstanding.
          if (inflight == 3'd0) begin
            byte_cnt <= '0;
            partial  <= '0;
            state    <= ACTIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sram_fifo_reader_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (BUS_CLK),
    .rst_n   (BUS_RST_N),
    .push    (push),
    .wr_data ({USB_DATA, partial}),
    .pop     (pop),
    .rd_data (DATA_OUT),
    .count   (buf_count)
  );

  assign DATA_VALID = (buf_count != '0);
  assign BUSY       = (inflight != 3'd0) || (byte_cnt != 2'd0) || (state == DRAIN);
  assign ERROR      = error_q;
  assign WORD_CNT   = word_cnt_q;

endmodule
